// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Brief    : Shared types and encodings for the multicycle RV32 control FSM.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_out_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_out_decode
// Brief    : Combinational state-to-control-vector decode for the RV32 FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_out_decode
    import rv_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                // PC+4 and IR load only on the edge the memory accepts
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_BRANCH;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multicycle RV32 datapath (R/lw/sw/beq).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    state_t           w_next;
    ctrl_t            w_ctrl;
    logic             w_retire;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

    ctrl_out_decode u_ctrl_out_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_RTYPE:          w_next = S_EXECUTE;
                    OP_BRANCH:         w_next = S_BRANCH;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECUTE:   w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_FETCH;
        endcase
    end

    // A store retires on the write-accept edge; everything else on its last state
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEM_WB, S_ALU_WB, S_BRANCH: w_retire = 1'b1;
            S_MEM_WRITE:                  w_retire = mem_ready;
            default:                      w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (r_state == S_DECODE && w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign pc_source     = w_ctrl.pc_source;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign illegal_instr = r_illegal;
    assign instret       = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control with a micro-step model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
    logic             ir_write, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op;
    logic             illegal_instr;
    logic [CNT_W-1:0] instret;
    logic [13:0]      w_act;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_instr(illegal_instr),
        .instret(instret)
    );

    always #5 clk = ~clk;

    assign w_act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};

    int n_total = 0;
    int n_bad   = 0;
    int n_rw    = 0;
    int n_irw   = 0;
    int n_mw    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] cw(input logic pcw, input logic pcc, input logic pcs,
                                       input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop);
        return {pcw, pcc, pcs, iod, mr, mw, irw, m2r, rw, asa, asb, aop};
    endfunction

    // Instruction micro-program steps: control word plus how the step advances
    typedef struct {
        logic [13:0] word;
        bit          is_fetch;
        bit          waits;
        bit          retires;
        bit          is_decode;
        bit          is_trap;
    } step_t;

    function automatic step_t mk(input logic [13:0] w, input bit f, input bit wt,
                                 input bit r, input bit d, input bit t);
        step_t s;
        s.word = w; s.is_fetch = f; s.waits = wt; s.retires = r; s.is_decode = d; s.is_trap = t;
        return s;
    endfunction

    step_t st_fetch, st_decode, st_addr, st_rd, st_wb, st_wr, st_exec, st_alu_wb, st_br, st_trap;
    step_t m_q[$];
    step_t m_s;
    bit    m_valid = 0;
    int    m_cnt   = 0;
    logic  m_ill   = 1'b0;

    initial begin
        st_fetch  = mk(cw(0,0,0,0,1,0,0,0,0,0,2'b01,2'b00), 1, 1, 0, 0, 0);
        st_decode = mk(cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00), 0, 0, 0, 1, 0);
        st_addr   = mk(cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00), 0, 0, 0, 0, 0);
        st_rd     = mk(cw(0,0,0,1,1,0,0,0,0,0,2'b00,2'b00), 0, 1, 0, 0, 0);
        st_wb     = mk(cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00), 0, 0, 1, 0, 0);
        st_wr     = mk(cw(0,0,0,1,0,1,0,0,0,0,2'b00,2'b00), 0, 1, 1, 0, 0);
        st_exec   = mk(cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10), 0, 0, 0, 0, 0);
        st_alu_wb = mk(cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00), 0, 0, 1, 0, 0);
        st_br     = mk(cw(0,1,1,0,0,0,0,0,0,1,2'b00,2'b01), 0, 0, 1, 0, 0);
        st_trap   = mk(14'd0, 0, 0, 0, 0, 1);
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                m_q.delete();
                m_q.push_back(st_fetch);
                m_q.push_back(st_decode);
                m_cnt   = 0;
                m_ill   = 1'b0;
                m_valid = 1;
            end else if (m_valid) begin
                m_s = m_q[0];
                if (!m_s.is_trap && !(m_s.waits && !mem_ready)) begin
                    void'(m_q.pop_front());
                    if (m_s.retires) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    if (m_s.is_decode) begin
                        case (opcode)
                            7'b0000011: begin m_q.push_back(st_addr); m_q.push_back(st_rd); m_q.push_back(st_wb); end
                            7'b0100011: begin m_q.push_back(st_addr); m_q.push_back(st_wr); end
                            7'b0110011: begin m_q.push_back(st_exec); m_q.push_back(st_alu_wb); end
                            7'b1100011: m_q.push_back(st_br);
                            default: begin m_q.push_back(st_trap); m_ill = 1'b1; end
                        endcase
                    end
                    if (m_q.size() == 0) begin
                        m_q.push_back(st_fetch);
                        m_q.push_back(st_decode);
                    end
                end
            end
        end
    end

    logic [13:0] r_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                r_exp = m_q[0].word;
                if (m_q[0].is_fetch) begin
                    r_exp[13] = mem_ready;
                    r_exp[7]  = mem_ready;
                end
                check("ctrl_vec", {18'd0, w_act}, {18'd0, r_exp});
                check("instret", {28'd0, instret}, m_cnt);
                check("illegal", {31'd0, illegal_instr}, {31'd0, m_ill});
                if (reg_write === 1'b1) n_rw++;
                if (ir_write === 1'b1) n_irw++;
                if (mem_write === 1'b1 && i_or_d === 1'b1) n_mw++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input logic rdy);
        mem_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    int snap;
    int snap2;

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
        @(posedge clk); #2;
        do_reset();

        check("rst_ctrl", {18'd0, w_act}, 32'h0204);
        check("rst_instret", {28'd0, instret}, 0);
        check("rst_illegal", {31'd0, illegal_instr}, 0);

        // R-type, memory always ready
        opcode = 7'b0110011;
        snap = n_rw;
        tick(1); tick(1);
        check("rtype_alu_op", {30'd0, alu_op}, 2);
        tick(1);
        check("rtype_reg_write", {31'd0, reg_write}, 1);
        tick(1);
        check("rtype_instret", {28'd0, instret}, 1);
        check("model_instret", m_cnt, 1);

        // lw with 2 fetch stalls and 3 read stalls
        opcode = 7'b0000011;
        check("rtype_rw_pulses", n_rw - snap, 1);
        snap = n_irw;
        tick(0); tick(0);
        check("lw_fetch_stall_irw", {31'd0, ir_write}, 0);
        tick(1); tick(1); tick(1);
        for (int i = 0; i < 3; i++) begin
            tick(0);
            check("lw_stall_mem_read", {30'd0, mem_read, i_or_d}, 3);
        end
        tick(1);
        check("lw_mem_wb", {30'd0, reg_write, mem_to_reg}, 3);
        check("lw_instret_before", {28'd0, instret}, 1);
        tick(1);
        check("lw_instret_after", {28'd0, instret}, 2);

        // sw then beq from a fresh reset
        opcode = 7'b0100011;
        do_reset();
        check("lw_irw_pulses", n_irw - snap, 1);
        snap = n_mw;
        tick(1); tick(1); tick(1); tick(1);
        opcode = 7'b1100011;
        check("sw_instret", {28'd0, instret}, 1);
        tick(1); tick(1);
        check("beq_alu_op", {30'd0, alu_op}, 1);
        check("beq_pc_write_cond", {31'd0, pc_write_cond}, 1);
        tick(1);
        check("swbeq_instret", {28'd0, instret}, 2);
        check("model_swbeq", m_cnt, 2);

        // illegal opcode traps and holds
        opcode = 7'b1111111;
        check("sw_mw_pulses", n_mw - snap, 1);
        tick(1);
        check("pre_trap_illegal", {31'd0, illegal_instr}, 0);
        tick(1);
        check("trap_illegal", {31'd0, illegal_instr}, 1);
        for (int i = 0; i < 20; i++) begin
            tick(logic'(i[0]));
            check("trap_hold_ctrl", {18'd0, w_act}, 0);
            check("trap_hold_instret", {28'd0, instret}, 2);
        end

        // reset in the middle of a stalled lw read
        do_reset();
        check("trap_cleared", {31'd0, illegal_instr}, 0);
        opcode = 7'b0000011;
        snap2 = n_rw;
        tick(1); tick(1); tick(1);
        tick(0);
        check("mid_in_read", {30'd0, mem_read, i_or_d}, 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_fetch_ctrl", {18'd0, w_act}, 32'h2284);
        check("mid_instret", {28'd0, instret}, 0);
        tick(0); tick(0); tick(0);
        check("mid_still_fetch", {31'd0, mem_read}, 1);
        check("mid_no_reg_write", n_rw - snap2, 0);

        // counter wrap with back-to-back beq
        do_reset();
        opcode = 7'b1100011;
        for (int i = 1; i <= 17; i++) begin
            tick(1); tick(1); tick(1);
            if (i == 15) check("wrap_f", {28'd0, instret}, 32'hF);
            if (i == 16) check("wrap_0", {28'd0, instret}, 0);
            if (i == 17) check("wrap_1", {28'd0, instret}, 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
